// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//   640x480@60Hz VGA timing generator. Everything runs on CLK_NX; the 25 MHz
//   pixel_rate square wave from the clock divider is treated as data and
//   edge-detected, so one rising edge of pixel_rate advances one pixel.
//
// Ports
//   CLK_NX      in   1   system clock (the only clock)
//   reset       in   1   synchronous, active-high reset
//   pixel_rate  in   1   pixel-rate square wave; rising edge = one pixel
//   hsync       out  1   horizontal sync, active low
//   vsync       out  1   vertical sync, active low
//   video_on    out  1   presented pixel lies inside the visible area
//   pixel_x     out  10  column of the presented pixel
//   pixel_y     out  10  line of the presented pixel
//   pixel_tick  out  1   one-cycle strobe: outputs changed on this edge
//   frame_start out  1   one-cycle strobe: presented pixel is (0,0)
// ---------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       CLK_NX,
    input  logic       reset,
    input  logic       pixel_rate,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pixel_tick,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Boundaries are 11 bits wide so a 1024-entry total with no back porch
    // still has a representable sync end.
    localparam logic [10:0] H_VIS_END  = 11'(H_DISPLAY);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] H_SYNC_END = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END  = 11'(V_DISPLAY);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] V_SYNC_END = 11'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);

    logic        pr_q;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;

    logic        tick_s;
    logic        h_wrap_s;
    logic [9:0]  h_next_s;
    logic [9:0]  v_next_s;
    logic [10:0] h_wide_s;
    logic [10:0] v_wide_s;
    logic        video_s;
    logic        hsync_s;
    logic        vsync_s;
    logic        frame_s;

    // Edge detect, next-count computation and decode of the current position.
    always_comb begin
        tick_s   = pixel_rate & ~pr_q;
        h_wrap_s = (h_cnt == H_LAST);
        h_wide_s = {1'b0, h_cnt};
        v_wide_s = {1'b0, v_cnt};

        if (h_wrap_s) begin
            h_next_s = 10'd0;
        end else begin
            h_next_s = h_cnt + 10'd1;
        end

        // The line counter only moves when the column counter wraps.
        if (!h_wrap_s) begin
            v_next_s = v_cnt;
        end else if (v_cnt == V_LAST) begin
            v_next_s = 10'd0;
        end else begin
            v_next_s = v_cnt + 10'd1;
        end

        video_s = (h_wide_s < H_VIS_END) & (v_wide_s < V_VIS_END);
        hsync_s = ~((h_wide_s >= H_SYNC_BEG) & (h_wide_s < H_SYNC_END));
        vsync_s = ~((v_wide_s >= V_SYNC_BEG) & (v_wide_s < V_SYNC_END));
        frame_s = (h_cnt == 10'd0) & (v_cnt == 10'd0);
    end

    // Counters and registered outputs; reset wins over a coincident tick.
    always_ff @(posedge CLK_NX) begin
        if (reset) begin
            // pr_q=1 hides a level-high pixel_rate at release from the edge detector.
            pr_q        <= 1'b1;
            h_cnt       <= 10'd0;
            v_cnt       <= 10'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            pixel_x     <= 10'd0;
            pixel_y     <= 10'd0;
            pixel_tick  <= 1'b0;
            frame_start <= 1'b0;
        end else if (tick_s) begin
            pr_q        <= pixel_rate;
            h_cnt       <= h_next_s;
            v_cnt       <= v_next_s;
            hsync       <= hsync_s;
            vsync       <= vsync_s;
            video_on    <= video_s;
            pixel_x     <= h_cnt;
            pixel_y     <= v_cnt;
            pixel_tick  <= 1'b1;
            frame_start <= frame_s;
        end else begin
            pr_q        <= pixel_rate;
            pixel_tick  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
//   Drives two instances from the same stimulus: one with the nominal 640x480
//   timing and one with a tiny raster so vertical wrap, vsync and frame_start
//   are exercised within a short run. Each pixel_rate rising edge issued
//   pushes the expected presented pixel (derived from the count of edges
//   since reset) into a per-instance queue; a negedge monitor pops on every
//   pixel_tick and otherwise checks that outputs hold.
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       vo;
        logic       hs;
        logic       vs;
        logic       tk;
        logic       fs;
    } out_t;

    localparam out_t RST_V = '{x: 10'd0, y: 10'd0, vo: 1'b0, hs: 1'b1,
                               vs: 1'b1, tk: 1'b0, fs: 1'b0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pixel_rate = 1'b0;
    logic rst_d = 1'b1;

    logic       hs0, vs0, vo0, pt0, fs0;
    logic [9:0] px0, py0;
    logic       hs1, vs1, vo1, pt1, fs1;
    logic [9:0] px1, py1;

    out_t act [2];
    out_t q [2][$];
    out_t last_v [2];

    int checks = 0;
    int failures = 0;
    int n_ticks = 0;
    logic dut_pr = 1'b1;

    always #5 clk = ~clk;

    vga_sync_gen u_big (
        .CLK_NX(clk), .reset(reset), .pixel_rate(pixel_rate),
        .hsync(hs0), .vsync(vs0), .video_on(vo0),
        .pixel_x(px0), .pixel_y(py0),
        .pixel_tick(pt0), .frame_start(fs0)
    );

    vga_sync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) u_small (
        .CLK_NX(clk), .reset(reset), .pixel_rate(pixel_rate),
        .hsync(hs1), .vsync(vs1), .video_on(vo1),
        .pixel_x(px1), .pixel_y(py1),
        .pixel_tick(pt1), .frame_start(fs1)
    );

    assign act[0] = {px0, py0, vo0, hs0, vs0, pt0, fs0};
    assign act[1] = {px1, py1, vo1, hs1, vs1, pt1, fs1};

    function automatic out_t exp_of(input int n, input int hd, input int hf,
                                    input int hsw, input int hb, input int vd,
                                    input int vf, input int vsw, input int vb);
        out_t e;
        int ht, vt, x, y;
        ht = hd + hf + hsw + hb;
        vt = vd + vf + vsw + vb;
        x = n % ht;
        y = (n / ht) % vt;
        e.x  = 10'(x);
        e.y  = 10'(y);
        e.vo = (x < hd) && (y < vd);
        e.hs = !((x >= hd + hf) && (x < hd + hf + hsw));
        e.vs = !((y >= vd + vf) && (y < vd + vf + vsw));
        e.tk = 1'b1;
        e.fs = (x == 0) && (y == 0);
        return e;
    endfunction

    function automatic string fmt(input out_t v);
        return $sformatf("x=%0d y=%0d vo=%0b hs=%0b vs=%0b tk=%0b fs=%0b",
                         v.x, v.y, v.vo, v.hs, v.vs, v.tk, v.fs);
    endfunction

    task automatic compare(input int i, input string tag, input out_t e, input out_t a);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s dut=%0d at %0t: got %s, expected %s",
                     tag, i, $time, fmt(a), fmt(e));
        end
    endtask

    // One cycle of stimulus; the expected pixel is queued whenever the DUT
    // will see a 0->1 transition on its next edge outside reset.
    task automatic drive(input logic pr, input logic rst);
        @(posedge clk);
        #1;
        pixel_rate = pr;
        reset = rst;
        if (rst) begin
            n_ticks = 0;
        end else if (pr && !dut_pr) begin
            q[0].push_back(exp_of(n_ticks, 640, 16, 96, 48, 480, 10, 2, 33));
            q[1].push_back(exp_of(n_ticks, 8, 2, 3, 2, 6, 2, 2, 3));
            n_ticks++;
        end
        dut_pr = rst ? 1'b1 : pr;
    endtask

    task automatic pixels(input int cnt);
        repeat (cnt) begin
            drive(1'b1, 1'b0);
            drive(1'b1, 1'b0);
            drive(1'b0, 1'b0);
            drive(1'b0, 1'b0);
        end
    endtask

    // Remember whether the DUTs saw reset on the edge just taken.
    always @(posedge clk) rst_d <= reset;

    // Monitor: pop on every tick, otherwise require held levels and no strobes.
    always @(negedge clk) begin
        out_t e;
        out_t h;
        for (int i = 0; i < 2; i++) begin
            if (rst_d) begin
                compare(i, "reset_state", RST_V, act[i]);
                last_v[i] = RST_V;
            end else if (act[i].tk) begin
                if (q[i].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_tick dut=%0d at %0t: got %s, expected no tick",
                             i, $time, fmt(act[i]));
                end else begin
                    e = q[i].pop_front();
                    compare(i, "tick_pixel", e, act[i]);
                    last_v[i] = e;
                end
            end else begin
                h = last_v[i];
                h.tk = 1'b0;
                h.fs = 1'b0;
                compare(i, "hold", h, act[i]);
            end
        end
    end

    initial begin
        // Reset with pixel_rate low, then the first rising edge presents (0,0).
        repeat (3) drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        pixels(301);
        // Stall at x=300: pixel_rate held low, nothing may move.
        repeat (100) drive(1'b0, 1'b0);
        // Resume at x=301 and run past two line wraps to x=700.
        pixels(2000);
        // Reset mid-line, overlapping a rising edge of pixel_rate.
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        pixels(20);
        // Reset held and released while pixel_rate is high: no tick until a fresh edge.
        repeat (3) drive(1'b1, 1'b1);
        repeat (3) drive(1'b1, 1'b0);
        repeat (2) drive(1'b0, 1'b0);
        pixels(30);
        // pixel_rate stuck high after one edge.
        repeat (60) drive(1'b1, 1'b0);
        repeat (5) drive(1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (q[i].size() != 0) begin
                failures++;
                $display("FAIL missing_ticks dut=%0d: got %0d unconsumed, expected 0",
                         i, q[i].size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
